// File: rtl/fpu_pkg.sv
// fpu_pkg: shared result type and constants for the FPU divider path
package fpu_pkg;
  localparam int DIV_LATENCY = 26;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [26:0] mantissa;
    logic [4:0]  dest;
    logic        dbz;
  } fpu_div_result_t;
endpackage

// File: rtl/fpu_div_fifo.sv
// fpu_div_fifo: 2-deep first-word fall-through buffer of divider results
module fpu_div_fifo import fpu_pkg::*; (
  input  logic            clock,
  input  logic            resetn,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  fpu_div_result_t din,
  input  logic [4:0]      query_dest,
  output fpu_div_result_t head,
  output logic [1:0]      count,
  output logic            dest_present
);
  fpu_div_result_t mem [2];
  logic rd, wr, do_push, do_pop;
  assign do_pop = pop && count != 2'd0;
  assign do_push = push && (count != 2'd2 || do_pop);
  assign head = mem[rd];
  // dest_present looks only past the head, at the entry that stays behind after a pop
  assign dest_present = count == 2'd2 && mem[~rd].dest == query_dest;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else if (clear) begin
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      rd <= rd ^ do_pop;
      wr <= wr ^ do_push;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr] <= din;
  end
endmodule

// File: rtl/fpu_div_ctrl.sv
// fpu_div_ctrl: launches the iterative divider, tracks the in-flight op and buffers results for writeback
module fpu_div_ctrl import fpu_pkg::*; #(
  parameter int DIV_LATENCY = fpu_pkg::DIV_LATENCY,
  parameter int TIMEOUT = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_dest,
  input  logic        flush,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic [4:0]  div_dest_o,
  input  logic        div_valid,
  input  logic [26:0] div_mantissa,
  input  logic [7:0]  div_exponent,
  input  logic        div_sign,
  input  logic [4:0]  div_dest,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [26:0] wb_mantissa,
  output logic [7:0]  wb_exponent,
  output logic        wb_sign,
  output logic [4:0]  wb_dest,
  output logic        wb_dbz,
  output logic [31:0] busy_mask,
  output logic        err_timeout
);
  localparam int CW = $clog2((TIMEOUT > DIV_LATENCY ? TIMEOUT : DIV_LATENCY) + 1);
  logic busy, killed, dbz_tag, accept, push, pop, dest_present, clr_hit;
  logic [4:0] fly_dest;
  logic [CW-1:0] cnt;
  logic [1:0] fifo_count;
  logic [31:0] set_vec, clr_vec;
  fpu_div_result_t din, head;
  assign req_ready = !busy && fifo_count <= 2'd1 && !flush;
  assign accept = req_valid && req_ready;
  assign div_start = accept;
  assign div_a = req_a;
  assign div_b = req_b;
  assign div_dest_o = req_dest;
  assign push = busy && div_valid && !killed && !flush;
  assign pop = wb_valid && wb_ready;
  assign din = '{sign: div_sign, exponent: div_exponent, mantissa: div_mantissa, dest: div_dest, dbz: dbz_tag};
  assign wb_valid = fifo_count != 2'd0;
  assign wb_sign = head.sign;
  assign wb_exponent = head.exponent;
  assign wb_mantissa = head.mantissa;
  assign wb_dest = head.dest;
  assign wb_dbz = head.dbz;
  fpu_div_fifo u_fifo (
    .clock        (clock),
    .resetn       (resetn),
    .push         (push),
    .pop          (pop),
    .clear        (flush),
    .din          (din),
    .query_dest   (wb_dest),
    .head         (head),
    .count        (fifo_count),
    .dest_present (dest_present)
  );
  // a live in-flight op with the popped dest keeps its mask bit alive
  assign clr_hit = pop && !dest_present && !(busy && !killed && fly_dest == wb_dest);
  assign set_vec = accept ? 32'd1 << req_dest : '0;
  assign clr_vec = clr_hit ? 32'd1 << wb_dest : '0;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) busy_mask <= '0;
    else busy_mask <= flush ? '0 : (busy_mask & ~clr_vec) | set_vec;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy <= 1'b0;
      killed <= 1'b0;
      dbz_tag <= 1'b0;
      fly_dest <= '0;
      cnt <= '0;
      err_timeout <= 1'b0;
    end else if (accept) begin
      busy <= 1'b1;
      killed <= 1'b0;
      cnt <= '0;
      dbz_tag <= req_b[30:0] == '0;
      fly_dest <= req_dest;
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      if (flush) killed <= 1'b1;
      if (div_valid) busy <= 1'b0;
      else if (cnt == CW'(TIMEOUT - 1)) begin
        busy <= 1'b0;
        err_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_div_ctrl.sv
// tb_fpu_div_ctrl: directed stimulus with a transaction-level reference model checked every cycle
module tb_fpu_div_ctrl;
  import fpu_pkg::*;
  localparam int LAT = 26;
  localparam int TMO = 32;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic req_valid = 1'b0, flush = 1'b0, wb_ready = 1'b1;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0] req_dest = '0;
  logic div_valid = 1'b0, div_sign = 1'b0;
  logic [26:0] div_mantissa = '0;
  logic [7:0] div_exponent = '0;
  logic [4:0] div_dest = '0;
  logic req_ready, div_start, wb_valid, wb_sign, wb_dbz, err_timeout;
  logic [31:0] div_a, div_b, busy_mask;
  logic [4:0] div_dest_o, wb_dest;
  logic [26:0] wb_mantissa;
  logic [7:0] wb_exponent;
  int passed = 0, total = 0;

  fpu_div_ctrl #(.DIV_LATENCY(LAT), .TIMEOUT(TMO)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_dest(req_dest), .flush(flush),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_dest_o(div_dest_o),
    .div_valid(div_valid), .div_mantissa(div_mantissa), .div_exponent(div_exponent),
    .div_sign(div_sign), .div_dest(div_dest), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_mantissa(wb_mantissa), .wb_exponent(wb_exponent), .wb_sign(wb_sign),
    .wb_dest(wb_dest), .wb_dbz(wb_dbz), .busy_mask(busy_mask), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // divider model: pulses div_valid in the cycle after the LAT-th edge following the start edge
  logic start_q = 1'b0, div_en = 1'b1;
  logic [31:0] sa, sb, oa, ob;
  logic [4:0] sd, od;
  int pend = 0, pulses = 0;
  always @(negedge clock) begin
    start_q = div_start;
    sa = div_a;
    sb = div_b;
    sd = div_dest_o;
  end
  initial forever begin
    @(posedge clock);
    #1;
    div_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && div_en) begin
        div_valid = 1'b1;
        pulses++;
        div_sign = oa[31] ^ ob[31];
        div_exponent = 8'(int'(oa[30:23]) - int'(ob[30:23]) + 127);
        div_mantissa = 27'((longint'({1'b1, oa[22:0]}) << 26) / longint'({1'b1, ob[22:0]}));
        div_dest = od;
      end
    end
    if (start_q && resetn) begin
      pend = LAT;
      oa = sa;
      ob = sb;
      od = sd;
    end
  end

  // reference model: queue of buffered results plus one in-flight op
  fpu_div_result_t m_q[$];
  logic m_busy = 1'b0, m_killed = 1'b0, m_err = 1'b0, m_dbz = 1'b0;
  logic [4:0] m_dest = '0;
  logic [31:0] m_stale = '0;
  int m_age = 0;

  function automatic logic [31:0] exp_mask();
    logic [31:0] m;
    m = m_stale;
    foreach (m_q[i]) m[m_q[i].dest] = 1'b1;
    if (m_busy && !m_killed) m[m_dest] = 1'b1;
    return m;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_busy = 1'b0;
    m_killed = 1'b0;
    m_err = 1'b0;
    m_stale = '0;
    m_age = 0;
  endtask

  task automatic m_step();
    logic ready, acc;
    ready = !m_busy && m_q.size() <= 1 && !flush;
    acc = req_valid && ready;
    if (wb_ready && m_q.size() != 0) begin
      m_stale[m_q[0].dest] = 1'b0;
      void'(m_q.pop_front());
    end
    if (m_busy) begin
      m_age++;
      if (div_valid) begin
        if (!m_killed && !flush)
          m_q.push_back('{sign: div_sign, exponent: div_exponent, mantissa: div_mantissa, dest: div_dest, dbz: m_dbz});
        m_busy = 1'b0;
      end else if (m_age == TMO) begin
        m_err = 1'b1;
        m_busy = 1'b0;
        if (!m_killed) m_stale[m_dest] = 1'b1;
      end
      if (flush) m_killed = 1'b1;
    end
    if (flush) begin
      m_q.delete();
      m_stale = '0;
    end
    if (acc) begin
      m_busy = 1'b1;
      m_killed = 1'b0;
      m_age = 0;
      m_dest = req_dest;
      m_dbz = req_b[30:0] == '0;
    end
  endtask

  initial forever begin
    logic exp_ready;
    @(negedge clock);
    if (!resetn) m_reset();
    exp_ready = !m_busy && m_q.size() <= 1 && !flush;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("div_start", 64'(div_start), 64'(req_valid && exp_ready));
    check("wb_valid", 64'(wb_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) check("wb_head", 64'({wb_sign, wb_exponent, wb_mantissa, wb_dest, wb_dbz}), 64'(m_q[0]));
    check("busy_mask", 64'(busy_mask), 64'(exp_mask()));
    check("err_timeout", 64'(err_timeout), 64'(m_err));
    if (resetn) m_step();
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("issue_ready", 64'(req_ready), 64'(1));
    req_a = a;
    req_b = b;
    req_dest = d;
    req_valid = 1'b1;
    check("div_a_pass", 64'(div_a), 64'(a));
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int n, first, p0;
    logic seen_wb;
    #1 resetn = 1'b0;
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_mask", 64'(busy_mask), 64'(0));
    check("rst_err", 64'(err_timeout), 64'(0));
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    // single divide 6.0 / 2.0
    issue(32'h40C00000, 32'h40000000, 5'd5);
    check("single_mask_set", 64'(busy_mask[5]), 64'(1));
    n = 0;
    while (!wb_valid && n < 60) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("single_latency", 64'(n), 64'(27));
    check("single_sign", 64'(wb_sign), 64'(0));
    check("single_exp", 64'(wb_exponent), 64'(128));
    check("single_mant", 64'(wb_mantissa), 64'(27'h6000000));
    check("single_dest", 64'(wb_dest), 64'(5));
    check("single_dbz", 64'(wb_dbz), 64'(0));
    check("single_mask_held", 64'(busy_mask[5]), 64'(1));
    @(posedge clock);
    #1;
    check("single_popped", 64'(wb_valid), 64'(0));
    check("single_mask_clr", 64'(busy_mask[5]), 64'(0));
    // divide by zero 1.0 / 0.0
    issue(32'h3F800000, 32'h00000000, 5'd12);
    n = 0;
    while (!wb_valid && n < 60) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("dbz_flag", 64'(wb_dbz), 64'(1));
    check("dbz_dest", 64'(wb_dest), 64'(12));
    @(posedge clock);
    #1;
    // back-pressure: two results to the same register held in the FIFO
    wb_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000, 5'd7);
    issue(32'h3F800000, 32'h40000000, 5'd7);
    repeat (30) begin
      @(posedge clock);
      #1;
    end
    check("bp_full_ready", 64'(req_ready), 64'(0));
    check("bp_head_valid", 64'(wb_valid), 64'(1));
    check("bp_head_exp", 64'(wb_exponent), 64'(128));
    wb_ready = 1'b1;
    @(posedge clock);
    #1;
    check("bp_second_valid", 64'(wb_valid), 64'(1));
    check("bp_second_exp", 64'(wb_exponent), 64'(126));
    check("bp_mask_kept", 64'(busy_mask[7]), 64'(1));
    @(posedge clock);
    #1;
    check("bp_empty", 64'(wb_valid), 64'(0));
    check("bp_ready_back", 64'(req_ready), 64'(1));
    check("bp_mask_clr", 64'(busy_mask[7]), 64'(0));
    // flush 10 cycles after accept
    issue(32'h40C00000, 32'h40000000, 5'd3);
    first = -1;
    seen_wb = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (i == 11) check("flush_mask", 64'(busy_mask), 64'(0));
      if (req_ready && first < 0) first = i;
      seen_wb = seen_wb | wb_valid;
      flush = i == 10;
    end
    flush = 1'b0;
    check("flush_ready_at", 64'(first), 64'(27));
    check("flush_no_wb", 64'(seen_wb), 64'(0));
    // timeout with the divider silent
    div_en = 1'b0;
    issue(32'h40C00000, 32'h40000000, 5'd9);
    n = 0;
    while (!err_timeout && n < 60) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("timeout_at", 64'(n), 64'(TMO));
    check("timeout_ready", 64'(req_ready), 64'(1));
    div_en = 1'b1;
    // asynchronous reset 5 cycles after accept
    issue(32'h40C00000, 32'h40000000, 5'd4);
    p0 = pulses;
    repeat (5) @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    check("arst_ready", 64'(req_ready), 64'(1));
    check("arst_start", 64'(div_start), 64'(0));
    check("arst_wb_valid", 64'(wb_valid), 64'(0));
    check("arst_mask", 64'(busy_mask), 64'(0));
    check("arst_err", 64'(err_timeout), 64'(0));
    @(posedge clock);
    #1 resetn = 1'b1;
    seen_wb = 1'b0;
    repeat (30) begin
      @(posedge clock);
      #1;
      seen_wb = seen_wb | wb_valid;
    end
    check("arst_late_pulse", 64'(pulses - p0), 64'(1));
    check("arst_no_wb", 64'(seen_wb), 64'(0));
    check("arst_ready_end", 64'(req_ready), 64'(1));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
